// File: rtl/z80fi_ir_monitor.sv
// Cross-instruction shadow tracker for the Z80 I and R registers on the z80fi retirement stream.
// Optional R tracking is compiled in with the Z80FI_IR_MON_R_EN macro.
module z80fi_ir_monitor #(
  parameter int unsigned ERR_CNT_W   = 8,
  parameter bit          STOP_ON_ERR = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 z80fi_valid,
  input  logic [31:0]          z80fi_insn,
  input  logic [2:0]           z80fi_insn_len,
  input  logic [1:0]           z80fi_m1_count,
  input  logic [7:0]           z80fi_a_rdata,
  input  logic [7:0]           z80fi_a_wdata,
  input  logic [7:0]           z80fi_i_rdata,
  input  logic [7:0]           z80fi_i_wdata,
  input  logic [7:0]           z80fi_r_rdata,
  input  logic [7:0]           z80fi_r_wdata,
  output logic                 shadow_valid,
  output logic [7:0]           shadow_i,
  output logic [7:0]           shadow_r,
  output logic                 err_pulse,
  output logic [2:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [15:0]          insn_count
);

  typedef enum logic [1:0] {StUnsync, StTrack, StFault} state_e;

  state_e                state_q, state_d;
  logic                  shadow_valid_q, shadow_valid_d;
  logic [7:0]            shadow_i_q, shadow_i_d;
  logic                  err_pulse_q, err_pulse_d;
  logic [2:0]            err_code_q, err_code_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
  logic [15:0]           insn_count_q, insn_count_d;

  logic       is_ed2, is_ldia, is_ldai;
  logic [7:0] exp_i;
  logic [2:0] chk_code;

  assign is_ed2  = (z80fi_insn_len == 3'd2);
  assign is_ldia = is_ed2 && (z80fi_insn[15:0] == 16'h47ED);
  assign is_ldai = is_ed2 && (z80fi_insn[15:0] == 16'h57ED);
  assign exp_i   = is_ldia ? z80fi_a_rdata : z80fi_i_rdata;

`ifdef Z80FI_IR_MON_R_EN
  logic       is_ldra, is_ldar;
  logic [1:0] m1_eff;
  logic [7:0] shadow_r_q, shadow_r_d;
  logic [7:0] exp_r, ldar_a;
  logic       unused_insn;

  assign is_ldra = is_ed2 && (z80fi_insn[15:0] == 16'h4FED);
  assign is_ldar = is_ed2 && (z80fi_insn[15:0] == 16'h5FED);
  assign m1_eff  = (z80fi_m1_count == 2'd0) ? 2'd1 : z80fi_m1_count;
  // Refresh counter only advances the low 7 bits; bit 7 is software-owned.
  assign exp_r   = is_ldra ? z80fi_a_rdata
                           : {shadow_r_q[7], shadow_r_q[6:0] + {5'd0, m1_eff}};
  assign ldar_a  = {shadow_r_q[7], shadow_r_q[6:0] + 7'd2};
  assign shadow_r    = shadow_r_q;
  assign unused_insn = ^z80fi_insn[31:16];
`else
  logic unused_r;
  assign shadow_r = 8'h00;
  assign unused_r = ^{z80fi_insn[31:16], z80fi_r_rdata, z80fi_r_wdata, z80fi_m1_count};
`endif

  // Lowest-numbered failing check wins.
  always_comb begin
    chk_code = 3'd0;
    if (z80fi_i_rdata != shadow_i_q) begin
      chk_code = 3'd1;
    end else if (z80fi_i_wdata != exp_i) begin
      chk_code = 3'd2;
`ifdef Z80FI_IR_MON_R_EN
    end else if (z80fi_r_rdata != shadow_r_q) begin
      chk_code = 3'd3;
    end else if (z80fi_r_wdata != exp_r) begin
      chk_code = 3'd4;
    end else if (is_ldar && (z80fi_a_wdata != ldar_a)) begin
      chk_code = 3'd5;
`endif
    end else if (is_ldai && (z80fi_a_wdata != shadow_i_q)) begin
      chk_code = 3'd5;
    end
  end

  always_comb begin
    state_d      = state_q;
    shadow_i_d   = shadow_i_q;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
    err_count_d  = err_count_q;
    insn_count_d = insn_count_q;
`ifdef Z80FI_IR_MON_R_EN
    shadow_r_d   = shadow_r_q;
`endif
    unique case (state_q)
      StUnsync: begin
        if (z80fi_valid) begin
          shadow_i_d   = z80fi_i_wdata;
`ifdef Z80FI_IR_MON_R_EN
          shadow_r_d   = z80fi_r_wdata;
`endif
          insn_count_d = insn_count_q + 16'd1;
          state_d      = StTrack;
        end
      end
      StTrack: begin
        if (z80fi_valid) begin
          if (chk_code == 3'd0) begin
            shadow_i_d   = exp_i;
`ifdef Z80FI_IR_MON_R_EN
            shadow_r_d   = exp_r;
`endif
            insn_count_d = insn_count_q + 16'd1;
          end else begin
            err_pulse_d = 1'b1;
            if (err_code_q == 3'd0) begin
              err_code_d = chk_code;
            end
            if (err_count_q != {ERR_CNT_W{1'b1}}) begin
              err_count_d = err_count_q + ERR_CNT_W'(1);
            end
            state_d = STOP_ON_ERR ? StFault : StUnsync;
          end
        end
      end
      StFault: ;
      default: state_d = StUnsync;
    endcase
    shadow_valid_d = (state_d == StTrack);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StUnsync;
      shadow_valid_q <= 1'b0;
      shadow_i_q     <= 8'h00;
      err_pulse_q    <= 1'b0;
      err_code_q     <= 3'd0;
      err_count_q    <= '0;
      insn_count_q   <= 16'd0;
    end else begin
      state_q        <= state_d;
      shadow_valid_q <= shadow_valid_d;
      shadow_i_q     <= shadow_i_d;
      err_pulse_q    <= err_pulse_d;
      err_code_q     <= err_code_d;
      err_count_q    <= err_count_d;
      insn_count_q   <= insn_count_d;
    end
  end

`ifdef Z80FI_IR_MON_R_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_r_q <= 8'h00;
    end else begin
      shadow_r_q <= shadow_r_d;
    end
  end
`endif

  assign shadow_valid = shadow_valid_q;
  assign shadow_i     = shadow_i_q;
  assign err_pulse    = err_pulse_q;
  assign err_code     = err_code_q;
  assign err_count    = err_count_q;
  assign insn_count   = insn_count_q;

endmodule

// File: tb/tb_z80fi_ir_monitor.sv
// Scoreboard bench for z80fi_ir_monitor: two instances (stop-on-error, and resync with a 2-bit
// counter) share one retirement stream; Z80FI_IR_MON_R_EN selects the R-tracking expectations.
module tb_z80fi_ir_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] insn = '0;
  logic [2:0]  len = '0;
  logic [1:0]  m1 = '0;
  logic [7:0]  a_r = '0, a_w = '0, i_r = '0, i_w = '0, r_r = '0, r_w = '0;

  logic        a_sv, b_sv, a_ep, b_ep;
  logic [7:0]  a_si, a_sr, b_si, b_sr, a_cnt;
  logic [1:0]  b_cnt;
  logic [2:0]  a_ec, b_ec;
  logic [15:0] a_ic, b_ic;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  z80fi_ir_monitor #(.ERR_CNT_W(8), .STOP_ON_ERR(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .z80fi_valid(valid), .z80fi_insn(insn),
    .z80fi_insn_len(len), .z80fi_m1_count(m1), .z80fi_a_rdata(a_r), .z80fi_a_wdata(a_w),
    .z80fi_i_rdata(i_r), .z80fi_i_wdata(i_w), .z80fi_r_rdata(r_r), .z80fi_r_wdata(r_w),
    .shadow_valid(a_sv), .shadow_i(a_si), .shadow_r(a_sr), .err_pulse(a_ep),
    .err_code(a_ec), .err_count(a_cnt), .insn_count(a_ic)
  );

  z80fi_ir_monitor #(.ERR_CNT_W(2), .STOP_ON_ERR(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .z80fi_valid(valid), .z80fi_insn(insn),
    .z80fi_insn_len(len), .z80fi_m1_count(m1), .z80fi_a_rdata(a_r), .z80fi_a_wdata(a_w),
    .z80fi_i_rdata(i_r), .z80fi_i_wdata(i_w), .z80fi_r_rdata(r_r), .z80fi_r_wdata(r_w),
    .shadow_valid(b_sv), .shadow_i(b_si), .shadow_r(b_sr), .err_pulse(b_ep),
    .err_code(b_ec), .err_count(b_cnt), .insn_count(b_ic)
  );

  typedef struct {
    logic        sv;
    logic [7:0]  si;
    logic [7:0]  sr;
    logic        ep;
    logic [2:0]  ec;
    logic [7:0]  cnt;
    logic [15:0] ic;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  localparam int MU = 0, MT = 1, MF = 2;
  int          m_state[2];
  logic [7:0]  m_si[2];
  logic [7:0]  m_sr[2];
  logic        m_ep[2];
  logic [2:0]  m_ec[2];
  int          m_cnt[2];
  logic [15:0] m_ic[2];
  int          m_max[2] = '{255, 3};
  bit          m_stop[2] = '{1'b1, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = MU; m_si[k] = 8'h00; m_sr[k] = 8'h00; m_ep[k] = 1'b0;
      m_ec[k] = 3'd0;  m_cnt[k] = 0;    m_ic[k] = 16'd0;
    end
  endtask

  task automatic model_step(input int k, output exp_t e);
    logic [15:0] op;
    logic [7:0]  ei;
    logic [2:0]  code;
    logic [6:0]  m1e;
`ifdef Z80FI_IR_MON_R_EN
    logic [7:0]  er;
    logic [7:0]  ea;
`endif
    m_ep[k] = 1'b0;
    if (valid && m_state[k] == MU) begin
      m_si[k] = i_w;
`ifdef Z80FI_IR_MON_R_EN
      m_sr[k] = r_w;
`endif
      m_ic[k] = m_ic[k] + 16'd1;
      m_state[k] = MT;
    end else if (valid && m_state[k] == MT) begin
      op  = (len == 3'd2) ? insn[15:0] : 16'h0000;
      m1e = (m1 == 2'd0) ? 7'd1 : {5'd0, m1};
      ei  = (op == 16'h47ED) ? a_r : i_r;
      code = 3'd0;
`ifdef Z80FI_IR_MON_R_EN
      er = m_sr[k];
      er[6:0] = m_sr[k][6:0] + m1e;
      if (op == 16'h4FED) er = a_r;
      ea = m_sr[k];
      ea[6:0] = m_sr[k][6:0] + 7'd2;
`endif
      if (i_r != m_si[k]) code = 3'd1;
      else if (i_w != ei) code = 3'd2;
`ifdef Z80FI_IR_MON_R_EN
      else if (r_r != m_sr[k]) code = 3'd3;
      else if (r_w != er) code = 3'd4;
      else if (op == 16'h5FED && a_w != ea) code = 3'd5;
`endif
      else if (op == 16'h57ED && a_w != m_si[k]) code = 3'd5;
      if (code == 3'd0) begin
        m_si[k] = ei;
`ifdef Z80FI_IR_MON_R_EN
        m_sr[k] = er;
`endif
        m_ic[k] = m_ic[k] + 16'd1;
      end else begin
        m_ep[k] = 1'b1;
        if (m_ec[k] == 3'd0) m_ec[k] = code;
        if (m_cnt[k] < m_max[k]) m_cnt[k]++;
        m_state[k] = m_stop[k] ? MF : MU;
      end
    end
    e.sv = (m_state[k] == MT); e.si = m_si[k]; e.sr = m_sr[k]; e.ep = m_ep[k];
    e.ec = m_ec[k]; e.cnt = 8'(m_cnt[k]); e.ic = m_ic[k];
  endtask

  task automatic step();
    exp_t e;
    model_step(0, e); q_a.push_back(e);
    model_step(1, e); q_b.push_back(e);
    @(posedge clk);
    #1;
    e = q_a.pop_front();
    check("a.shadow_valid", a_sv, e.sv); check("a.shadow_i", a_si, e.si);
    check("a.shadow_r", a_sr, e.sr);     check("a.err_pulse", a_ep, e.ep);
    check("a.err_code", a_ec, e.ec);     check("a.err_count", a_cnt, e.cnt);
    check("a.insn_count", a_ic, e.ic);
    e = q_b.pop_front();
    check("b.shadow_valid", b_sv, e.sv); check("b.shadow_i", b_si, e.si);
    check("b.shadow_r", b_sr, e.sr);     check("b.err_pulse", b_ep, e.ep);
    check("b.err_code", b_ec, e.ec);     check("b.err_count", b_cnt, e.cnt);
    check("b.insn_count", b_ic, e.ic);
  endtask

  task automatic retire(input logic [15:0] op, input logic [2:0] ln, input logic [1:0] m,
                        input logic [7:0] ar, input logic [7:0] aw, input logic [7:0] ir,
                        input logic [7:0] iw, input logic [7:0] rr, input logic [7:0] rw);
    valid = 1'b1; insn = {16'h0000, op}; len = ln; m1 = m;
    a_r = ar; a_w = aw; i_r = ir; i_w = iw; r_r = rr; r_w = rw;
    step();
    valid = 1'b0;
  endtask

  task automatic idle();
    valid = 1'b0;
    step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst.a.sv", a_sv, 0); check("rst.a.si", a_si, 0); check("rst.a.sr", a_sr, 0);
    check("rst.a.ep", a_ep, 0); check("rst.a.ec", a_ec, 0); check("rst.a.cnt", a_cnt, 0);
    check("rst.a.ic", a_ic, 0); check("rst.b.cnt", b_cnt, 0); check("rst.b.ic", b_ic, 0);
    model_reset();
    #2;
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [7:0] rc;
    model_reset();
    #2;
    do_reset();

    // Sync on a NOP, then a NOP whose R wraps within 7 bits.
    retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h7F);
    check("sync.shadow_i", a_si, 8'h3C);
    check("sync.valid", a_sv, 1'b1);
`ifdef Z80FI_IR_MON_R_EN
    check("sync.shadow_r", a_sr, 8'h7F);
`endif
    retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h7F, 8'h00);
    check("wrap.err_code", a_ec, 3'd0);
    check("wrap.err_pulse", a_ep, 1'b0);

`ifdef Z80FI_IR_MON_R_EN
    do_reset();
    retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'hFF);
    retire(16'h44ED, 3'd2, 2'd2, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'hFF, 8'h81);
    check("r7.ok.err_pulse", a_ep, 1'b0);
    check("r7.ok.shadow_r", a_sr, 8'h81);
    do_reset();
    retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'hFF);
    retire(16'h44ED, 3'd2, 2'd2, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'hFF, 8'h01);
    check("r7.bad.err_code", a_ec, 3'd4);
    check("r7.bad.err_pulse", a_ep, 1'b1);
    idle();
    check("r7.bad.pulse_once", a_ep, 1'b0);
`else
    retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h55, 8'h99);
    check("noR.err_pulse", a_ep, 1'b0);
    check("noR.shadow_r", a_sr, 8'h00);
`endif

    // LD I,A then LD A,I.
    do_reset();
    retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h10);
    retire(16'h47ED, 3'd2, 2'd2, 8'h5A, 8'h5A, 8'h3C, 8'h5A, 8'h10, 8'h12);
    check("ldia.err_pulse", a_ep, 1'b0);
    check("ldia.shadow_i", a_si, 8'h5A);
    retire(16'h57ED, 3'd2, 2'd2, 8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h12, 8'h14);
    check("ldai.err_code", a_ec, 3'd0);
    check("ldai.shadow_i", a_si, 8'h5A);
    do_reset();
    retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h10);
    retire(16'h47ED, 3'd2, 2'd2, 8'h5A, 8'h5A, 8'h3C, 8'h00, 8'h10, 8'h12);
    check("ldia.bad.err_code", a_ec, 3'd2);

    // Stop-on-error freeze, then reset clears it.
    do_reset();
    retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h10);
    retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h11, 8'h3C, 8'h10, 8'h11);
    check("stop.err_code", a_ec, 3'd1);
    for (int n = 0; n < 10; n++) begin
      retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h10, 8'h11);
    end
    check("stop.err_count", a_cnt, 8'd1);
    check("stop.insn_count", a_ic, 16'd1);
    check("stop.shadow_valid", a_sv, 1'b0);
    do_reset();

    // Saturating counter with resync between errors.
    retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h10);
    for (int n = 0; n < 5; n++) begin
      if (n == 0) retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h10, 8'h11);
      else        retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h77, 8'h3C, 8'h10, 8'h11);
      check("sat.b.err_pulse", b_ep, 1'b1);
      retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h10);
      check("sat.b.resync", b_sv, 1'b1);
    end
    check("sat.b.err_count", b_cnt, 2'd3);
    check("sat.b.err_code", b_ec, 3'd2);

    // insn_count wraps at 2^16.
    do_reset();
    retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00);
    rc = 8'h00;
    for (int n = 0; n < 65536; n++) begin
      retire(16'h0000, 3'd1, 2'd1, 8'h00, 8'h00, 8'h3C, 8'h3C, rc, {1'b0, rc[6:0] + 7'd1});
      rc = {1'b0, rc[6:0] + 7'd1};
      if (n == 65533) check("wrap.ic_max", a_ic, 16'hFFFF);
    end
    check("wrap.a.insn_count", a_ic, 16'd1);
    check("wrap.b.insn_count", b_ic, 16'd1);
    check("wrap.a.err_count", a_cnt, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z80fi_ir_monitor.md
# z80fi_ir_monitor

Sequential shadow-state monitor for the Z80 I and R special registers, fed by the z80fi retirement stream beside the per-instruction spec modules. It keeps shadow copies of I and R across retired instructions. It checks all four I/R transfer instructions (LD I,A; LD R,A; LD A,I; LD A,R) and the R refresh increment on every other instruction, and it reports mismatches with a sticky error code and a saturating error counter. Per-instruction spec modules see one retirement in isolation; this block adds cross-instruction state tracking.

## Interface

Parameters:
- ERR_CNT_W, 8: width of saturating error counter.
- STOP_ON_ERR, 1: 1 = freeze in FAULT after the first error; 0 = drop to UNSYNC and resynchronise.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- z80fi_valid  in  1  one instruction retires this cycle.
- z80fi_insn  in  32  instruction bytes; first byte in [7:0].
- z80fi_insn_len  in  3  instruction length in bytes.
- z80fi_m1_count  in  2  M1 (opcode fetch) cycles in this instruction, 1..3.
- z80fi_a_rdata / z80fi_a_wdata  in  8 each  A before / after.
- z80fi_i_rdata / z80fi_i_wdata  in  8 each  I before / after.
- z80fi_r_rdata / z80fi_r_wdata  in  8 each  R before / after.
- shadow_valid  out  1  shadows are synchronised.
- shadow_i, shadow_r  out  8 each  current shadow values.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  3  first error since reset; sticky.
- err_count  out  ERR_CNT_W  saturating error count.
- insn_count  out  16  retirements checked; wraps at 2^16.

## Operation

- Decode, using z80fi_insn[15:0] with len==2: LDIA=16'h47ED, LDRA=16'h4FED, LDAI=16'h57ED, LDAR=16'h5FED. All other values are OTHER.
- Expected R after any instruction: {R[7], R[6:0]+m1_count mod 128}. Bit 7 is never incremented. For LDRA the expected R is a_rdata.
- Expected I: a_rdata for LDIA; otherwise i_rdata.
- Expected A: LDAI gives shadow_i; LDAR gives {shadow_r[7], shadow_r[6:0]+2}.
- States:
  - UNSYNC (reset state): on valid, load shadows from the *_wdata fields with no check. Increment insn_count and go to TRACK.
  - TRACK: on valid, check in this order, where the lowest-numbered failing check becomes the code:
    1. i_rdata≠shadow_i
    2. i_wdata≠expected I
    3. r_rdata≠shadow_r
    4. r_wdata≠expected R
    5. a_wdata≠expected A (LDAI/LDAR only)
  - TRACK, no error: shadows take the expected values and insn_count increments.
  - TRACK, error: err_pulse fires. err_code is latched only if it is currently 0. err_count increments, saturating at all-ones. Next state is FAULT if STOP_ON_ERR=1, else UNSYNC. Shadows are not updated.
  - FAULT: ignores all inputs and holds every output except err_pulse, which is 0. Only reset_n leaves FAULT.
- shadow_valid = (state==TRACK).

## Timing

- All outputs are registered. Shadows, counters and err_pulse update on the edge after valid is sampled, so latency is 1 cycle.
- Back-to-back valid on every cycle is fully supported. The check for cycle n+1 uses the shadows as updated by cycle n.
- Reset values: state=UNSYNC, shadows=0, err_code=0, err_count=0, insn_count=0, err_pulse=0, shadow_valid=0.
- Asserting reset_n low mid-stream clears everything immediately. The first valid after release resynchronises.
- insn_count wraps from 16'hFFFF to 0. err_count holds at maximum.
- z80fi_m1_count=0 is treated as 1.

## Configuration

- Z80FI_IR_MON_R_EN defined: R tracking is compiled in, covering checks 3 and 4 and the LDAR A check.
- Z80FI_IR_MON_R_EN undefined:
  - shadow_r is tied to 0.
  - R checks and the LDAR A check are removed. LDRA and LDAR are treated as OTHER for the I check only.
  - Error codes 3 and 4 never occur.

## Test plan

- Reset, then retire NOP (insn 8'h00, m1=1) with i/r wdata 8'h3C/8'h7F: the block synchronises with shadow_i=8'h3C and shadow_r=8'h7F. Then retire NOP with r_rdata=8'h7F and r_wdata=8'h00: no error; R wraps within 7 bits.
- Synced with shadow_r=8'hFF, retire an ED-prefixed instruction with m1=2: expected r_wdata=8'h81. Drive 8'h81 for no error; drive 8'h01 for err_code=4 and err_pulse high for exactly 1 cycle.
- LDIA with a_rdata=8'h5A and i_wdata=8'h5A, then LDAI with a_wdata=8'h5A: no errors and shadow_i=8'h5A. Repeat with i_wdata=8'h00: err_code=2.
- STOP_ON_ERR=1: force an i_rdata mismatch so err_code=1, then send 10 further retirements. err_count stays 1, insn_count is frozen and shadow_valid=0. Pulse reset_n low: all outputs return to 0.
- STOP_ON_ERR=0, ERR_CNT_W=2: inject 5 consecutive errors with valid retirements between them. err_count saturates at 3, err_code holds the first code, and a valid retirement after each error resynchronises.
- Macro undefined: an R mismatch produces no error and shadow_r reads 8'h00.
